// File: rtl/ysyx_23060201_ifid_buf_if.sv
// Fetch/decode handshake bundle for the IF/ID elastic buffer.
// The master side is whoever drives fetch data and decode acceptance; the buffer is the slave.
interface ysyx_23060201_ifid_buf_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ADDR_WIDTH-1:0]   in_pc;
    logic [DATA_WIDTH-1:0]   in_inst;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDR_WIDTH-1:0]   out_pc;
    logic [DATA_WIDTH-1:0]   out_inst;
    logic [31:0]             out_imm;
    logic [2:0]              out_itype;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output in_valid, in_pc, in_inst, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_imm, out_itype, count
    );

    modport slave (
        input  in_valid, in_pc, in_inst, flush, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_imm, out_itype, count
    );
endinterface

// File: rtl/ysyx_23060201_ifid_buf.sv
// IF/ID elastic buffer: circular queue of {pc, inst} with flush, plus optional RV32I predecode.
// Predecode (immediate + format) is built only when YSYX_23060201_IFID_PREDECODE_EN is defined.
module ysyx_23060201_ifid_buf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic clk,
    input  logic rst,
    ysyx_23060201_ifid_buf_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
    logic [PW-1:0]         rptr;
    logic [PW-1:0]         wptr;
    logic [CW-1:0]         cnt;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_inst;

    // Ready/valid come purely from the occupancy counter, so no input-to-output path exists.
    assign bus.in_ready  = (cnt != CW'(DEPTH));
    assign bus.out_valid = (cnt != '0);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    assign head_inst     = inst_mem[rptr];
    assign bus.out_pc    = pc_mem[rptr];
    assign bus.out_inst  = head_inst;
    assign bus.count     = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                pc_mem[wptr]   <= bus.in_pc;
                inst_mem[wptr] <= bus.in_inst;
                wptr           <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef YSYX_23060201_IFID_PREDECODE_EN
    typedef enum logic [2:0] {
        IT_R   = 3'd0,
        IT_I   = 3'd1,
        IT_S   = 3'd2,
        IT_B   = 3'd3,
        IT_U   = 3'd4,
        IT_J   = 3'd5,
        IT_UNK = 3'd7
    } itype_t;

    itype_t      itype;
    logic [31:0] imm;

    always_comb begin
        itype = IT_UNK;
        imm   = '0;
        case (head_inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                itype = IT_I;
                imm   = {{20{head_inst[31]}}, head_inst[31:20]};
            end
            7'b0100011: begin
                itype = IT_S;
                imm   = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
            end
            7'b1100011: begin
                itype = IT_B;
                imm   = {{20{head_inst[31]}}, head_inst[7], head_inst[30:25],
                         head_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                itype = IT_U;
                imm   = {head_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                itype = IT_J;
                imm   = {{12{head_inst[31]}}, head_inst[19:12], head_inst[20],
                         head_inst[30:21], 1'b0};
            end
            7'b0110011: begin
                itype = IT_R;
            end
            default: begin
                itype = IT_UNK;
            end
        endcase
    end

    // An empty buffer reports zeros so the post-reset state is all-zero.
    assign bus.out_imm   = bus.out_valid ? imm : 32'd0;
    assign bus.out_itype = bus.out_valid ? itype : 3'd0;
`else
    assign bus.out_imm   = 32'd0;
    assign bus.out_itype = bus.out_valid ? 3'd7 : 3'd0;
`endif

endmodule

// File: doc/ysyx_23060201_ifid_buf.md
# ysyx_23060201_ifid_buf

Two-entry elastic buffer between the instruction fetch unit and the decode unit of the NPC core. It accepts `{pc, inst}` pairs from fetch under a valid/ready handshake, holds them in order, and presents the oldest entry to decode. It also sign-extends the RV32I immediate and classifies the format. A flush input discards all buffered entries when a jump redirects fetch.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: PC width.
- `DATA_WIDTH`, default 32: instruction width; only 32 is supported.
- `DEPTH`, default 2: entry count; power of two, ≥2.

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: fetch presents an entry.
- `in_ready`, output, 1: buffer can accept an entry.
- `in_pc`, input, ADDR_WIDTH: PC of the incoming instruction.
- `in_inst`, input, DATA_WIDTH: incoming instruction word.
- `flush`, input, 1: discard all entries (jump taken).
- `out_valid`, output, 1: head entry is valid.
- `out_ready`, input, 1: decode consumes the head entry.
- `out_pc`, output, ADDR_WIDTH: head entry PC.
- `out_inst`, output, DATA_WIDTH: head entry instruction.
- `out_imm`, output, 32: sign-extended immediate of the head entry.
- `out_itype`, output, 3: format of the head entry. 0 = R, 1 = I, 2 = S, 3 = B, 4 = U, 5 = J, 7 = unknown.
- `count`, output, $clog2(DEPTH)+1: number of occupied entries.

## Operation
- Storage is a circular array with read pointer `rptr`, write pointer `wptr` and counter `count`. Pointers wrap modulo DEPTH.
- A push occurs when `in_valid & in_ready`: the entry is written at `wptr` and `wptr` increments.
- A pop occurs when `out_valid & out_ready`: `rptr` increments.
- `in_ready = (count != DEPTH)`. It does not depend on `out_ready`, so there is no combinational path from input to output.
- `out_valid = (count != 0)`. The `out_*` signals are driven from entry `rptr`. Their value is don't-care when `out_valid=0`.
- Counter update:
  - Push and pop in the same cycle: `count` is unchanged; both pointers advance.
  - Push only: `count+1`.
  - Pop only: `count-1`.
- Boundary cases:
  - Full: a push is impossible, and a pop still proceeds.
  - Empty: there is no bypass, and a pop is impossible.
- Flush has priority over everything. When `flush=1`, the next state is `rptr=wptr=count=0`, and any push or pop in that cycle is dropped. `in_ready` is still computed from `count` during the flush cycle, but the pushed data is discarded.
- Reset gives the same next state as flush. All entry storage is also cleared to 0.
- Format is classified from `out_inst[6:0]`:
  - I: 0010011, 0000011, 1100111, 1110011
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - R: 0110011
  - Anything else is unknown.
- Immediate per RV32I spec, sign bit `inst[31]`:
  - R and unknown give `out_imm=0`.
  - U gives `{inst[31:12], 12'b0}`.

## Timing
- Latency is 1 cycle: an entry pushed at edge N is visible on `out_*` with `out_valid=1` after edge N.
- Throughput is 1 entry per cycle in steady state when `out_ready` is held high.
- After `rst` is sampled, all outputs are 0 on the next cycle: `out_valid=0`, `in_ready=1`, `count=0`, and `out_pc`, `out_inst`, `out_imm`, `out_itype` are 0.
- A reset asserted mid-stream drops all entries. No pop occurs in the reset cycle.
- A flush asserted at edge N gives `out_valid=0` after N. An entry pushed at edge N+1 appears after N+1.
- Handshake rules:
  - Fetch holds `in_pc`/`in_inst` stable while `in_valid & ~in_ready`.
  - Decode may drop `out_ready` at any time.

## Configuration
- `YSYX_23060201_IFID_PREDECODE_EN` defined:
  - `out_imm` and `out_itype` are computed combinationally from the head entry as above.
- Macro undefined:
  - The predecode logic is omitted.
  - `out_imm` is tied to 0 and `out_itype` to 7.
  - Handshake and storage behaviour are identical.

## Test plan
- Reset, then push pc=0x80000000 with inst=0x00500093 while `out_ready=0`. Required after 1 cycle: `out_valid=1`, `out_itype=1`, `out_imm=0x00000005`, `count=1`.
- Push 0xFE000EE3 then 0x123450B7 with `out_ready=0`:
  - After the second push: `count=2`, `in_ready=0`, and a third push is refused.
  - Head entry: `out_itype=3`, `out_imm=0xFFFFFFFC`.
  - Raise `out_ready`; the next head is `out_itype=4`, `out_imm=0x12345000`.
- Full buffer with `in_valid=1` and `out_ready=1` held for 8 cycles: exactly one pop per cycle; `count` stays ≤2; entries leave in push order, with pc incrementing by 4.
- With `count=2`, assert `flush` together with `in_valid=1` and `out_ready=1`:
  - Next cycle: `count=0`, `out_valid=0`, and nothing was popped.
  - Then push 0x0080006F: after 1 cycle, `out_itype=5`, `out_imm=0x00000008`.
- With `count=1`, assert `rst` for 1 cycle: all outputs are 0 and `in_ready=1`. Build with the macro undefined: the same stream gives `out_imm=0`, `out_itype=7`.
